alu_muldiv: RTL

//  Multi-cycle RV32M-style multiply/divide unit that runs alongside the single-cycle ALU in EX.

---
 rtl/alu_muldiv.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/alu_muldiv.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, with a valid/ready handshake on both sides.
module alu_muldiv #(
    parameter  int DATA_WIDTH = 32,
    parameter  int OP_WIDTH   = 3,
    localparam int CNT_W      = $clog2(DATA_WIDTH) + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [OP_WIDTH-1:0]   Operation,
    input  logic [DATA_WIDTH-1:0] SrcA,
    input  logic [DATA_WIDTH-1:0] SrcB,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] ALUResult,
    output logic                  busy
);

    localparam logic [OP_WIDTH-1:0] OP_MUL    = OP_WIDTH'(3'b000);
    localparam logic [OP_WIDTH-1:0] OP_MULH   = OP_WIDTH'(3'b001);
    localparam logic [OP_WIDTH-1:0] OP_MULHSU = OP_WIDTH'(3'b010);
    localparam logic [OP_WIDTH-1:0] OP_DIV    = OP_WIDTH'(3'b100);
    localparam logic [OP_WIDTH-1:0] OP_REM    = OP_WIDTH'(3'b110);

    localparam logic [DATA_WIDTH-1:0] MIN_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [OP_WIDTH-1:0]   r_op;
    logic                  r_neg_res;
    logic [DATA_WIDTH-1:0] r_mcand;
    logic [DATA_WIDTH-1:0] r_hi;
    logic [DATA_WIDTH-1:0] r_lo;
    logic [CNT_W-1:0]      r_cnt;
    logic [DATA_WIDTH-1:0] r_result;

    logic                  w_accept;
    logic                  w_is_div;
    logic                  w_a_signed;
    logic                  w_b_signed;
    logic                  w_a_neg;
    logic                  w_b_neg;
    logic [DATA_WIDTH-1:0] w_a_abs;
    logic [DATA_WIDTH-1:0] w_b_abs;
    logic                  w_neg_res;
    logic                  w_div_zero;
    logic                  w_div_ovf;
    logic                  w_special;
    logic [DATA_WIDTH-1:0] w_special_res;

    // Operand decode for the accepting cycle
    assign w_accept   = in_valid && (r_state == S_IDLE) && !flush;
    assign w_is_div   = Operation[2];
    assign w_a_signed = (Operation == OP_MULH) || (Operation == OP_MULHSU) ||
                        (Operation == OP_DIV)  || (Operation == OP_REM);
    assign w_b_signed = (Operation == OP_MULH) || (Operation == OP_DIV) ||
                        (Operation == OP_REM);
    assign w_a_neg    = w_a_signed && SrcA[DATA_WIDTH-1];
    assign w_b_neg    = w_b_signed && SrcB[DATA_WIDTH-1];
    assign w_a_abs    = w_a_neg ? (~SrcA + 1'b1) : SrcA;
    assign w_b_abs    = w_b_neg ? (~SrcB + 1'b1) : SrcB;
    // Remainder follows the dividend; quotient and product follow the sign xor
    assign w_neg_res  = (w_is_div && Operation[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);

    assign w_div_zero = w_is_div && (SrcB == '0);
    assign w_div_ovf  = ((Operation == OP_DIV) || (Operation == OP_REM)) &&
                        (SrcA == MIN_NEG) && (SrcB == '1);
    assign w_special  = w_div_zero || w_div_ovf;

    always_comb begin
        w_special_res = '0;
        if (w_div_zero) begin
            w_special_res = Operation[1] ? SrcA : '1;
        end else if (w_div_ovf) begin
            w_special_res = Operation[1] ? '0 : SrcA;
        end
    end

    // Iteration step: r_hi/r_lo hold accumulator/multiplier or remainder/quotient
    logic [DATA_WIDTH:0]     w_mul_sum;
    logic [DATA_WIDTH-1:0]   w_mul_hi;
    logic [DATA_WIDTH-1:0]   w_mul_lo;
    logic [DATA_WIDTH:0]     w_rem_sh;
    logic [DATA_WIDTH:0]     w_div_diff;
    logic                    w_div_ge;
    logic [DATA_WIDTH-1:0]   w_div_hi;
    logic [DATA_WIDTH-1:0]   w_div_lo;
    logic [DATA_WIDTH-1:0]   w_step_hi;
    logic [DATA_WIDTH-1:0]   w_step_lo;
    logic [2*DATA_WIDTH-1:0] w_prod;
    logic [2*DATA_WIDTH-1:0] w_prod_fix;
    logic [DATA_WIDTH-1:0]   w_div_val;
    logic [DATA_WIDTH-1:0]   w_final;

    assign w_mul_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mcand} : '0);
    assign w_mul_hi   = w_mul_sum[DATA_WIDTH:1];
    assign w_mul_lo   = {w_mul_sum[0], r_lo[DATA_WIDTH-1:1]};

    assign w_rem_sh   = {r_hi, r_lo[DATA_WIDTH-1]};
    assign w_div_diff = w_rem_sh - {1'b0, r_mcand};
    assign w_div_ge   = !w_div_diff[DATA_WIDTH];
    assign w_div_hi   = w_div_ge ? w_div_diff[DATA_WIDTH-1:0] : w_rem_sh[DATA_WIDTH-1:0];
    assign w_div_lo   = {r_lo[DATA_WIDTH-2:0], w_div_ge};

    assign w_step_hi  = r_op[2] ? w_div_hi : w_mul_hi;
    assign w_step_lo  = r_op[2] ? w_div_lo : w_mul_lo;

    assign w_prod     = {w_step_hi, w_step_lo};
    assign w_prod_fix = r_neg_res ? (~w_prod + 1'b1) : w_prod;
    assign w_div_val  = r_op[1] ? w_step_hi : w_step_lo;

    always_comb begin
        w_final = '0;
        if (r_op[2]) begin
            w_final = r_neg_res ? (~w_div_val + 1'b1) : w_div_val;
        end else if (r_op == OP_MUL) begin
            w_final = w_prod_fix[DATA_WIDTH-1:0];
        end else begin
            w_final = w_prod_fix[2*DATA_WIDTH-1:DATA_WIDTH];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        busy         = 1'b1;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (w_accept) begin
                    w_state_next = w_special ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (flush) begin
                    w_state_next = S_IDLE;
                end else if (r_cnt == CNT_W'(1)) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (flush || out_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op      <= '0;
            r_neg_res <= 1'b0;
            r_mcand   <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_cnt     <= '0;
            r_result  <= '0;
        end else begin
            if (r_state == S_IDLE && w_accept) begin
                r_op      <= Operation;
                r_neg_res <= w_neg_res;
                r_mcand   <= w_b_abs;
                r_hi      <= '0;
                r_lo      <= w_a_abs;
                r_cnt     <= CNT_W'(DATA_WIDTH);
                if (w_special) begin
                    r_result <= w_special_res;
                end
            end else if (r_state == S_CALC && !flush) begin
                r_hi  <= w_step_hi;
                r_lo  <= w_step_lo;
                r_cnt <= r_cnt - 1'b1;
                if (r_cnt == CNT_W'(1)) begin
                    r_result <= w_final;
                end
            end
        end
    end

    assign ALUResult = r_result;

endmodule
